program_loader: RTL and testbench

- Writable 16x8 program store with a byte-stream loader. Replaces the fixed instruction ROM feeding the processor's fetch path.
- Accepts a framed program over a valid/ready byte interface: header (length), body, then XOR checksum.
- Holds the processor in reset while loading. Releases it only after a good checksum.
- Serves instruction fetches with the same one-cycle registered read the fetch path already expects.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_prog_ram.sv | 24 ++
 rtl/program_loader.sv | 97 +++++++++
 tb/tb_program_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared sizes, opcode constants and loader state encoding.
package program_loader_pkg;
   localparam int DEPTH = 16;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam logic [DW-1:0] OP_HALT = 8'hFF;
   localparam logic [DW-1:0] FILL = OP_HALT;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_HDR    = 3'd2,
      S_BODY   = 3'd3,
      S_CSUM   = 3'd4,
      S_RUN    = 3'd5,
      S_HALTED = 3'd6,
      S_ERROR  = 3'd7
   } state_t;
   // A header is a word count in 1..DEPTH with the top three bits clear.
   function automatic logic hdr_ok(input logic [DW-1:0] b);
      return (b != '0) && (b <= DW'(DEPTH)) && (b[7:5] == 3'b000);
   endfunction
endpackage

// File: rtl/program_loader_prog_ram.sv
// prog_ram: DEPTH x DW program store, one write port and a registered read port.
module prog_ram
   import program_loader_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] addr_i,
   output logic [DW-1:0] data_o
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] data_q;
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   // Only the read register is reset; stored words survive reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) data_q <= '0;
      else         data_q <= mem_q[addr_i];
   end
   assign data_o = data_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader for the program store; holds the CPU until a good checksum.
module program_loader
   import program_loader_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_start_i,
   input  logic [DW-1:0] byte_i,
   input  logic          byte_valid_i,
   output logic          byte_ready_o,
   input  logic [AW-1:0] addr_i,
   output logic [DW-1:0] data_o,
   input  logic          halt_i,
   output logic          cpu_hold_o,
   output logic          loaded_o,
   output logic          load_err_o
);
   state_t        state_q, state_d;
   logic [AW:0]   wcnt_q, wcnt_d, len_q, len_d;
   logic [DW-1:0] csum_q, csum_d, wdata;
   logic          we, xfer;

   assign byte_ready_o = state_q inside {S_HDR, S_BODY, S_CSUM};
   assign loaded_o     = state_q inside {S_RUN, S_HALTED};
   assign cpu_hold_o   = !loaded_o;
   assign load_err_o   = state_q == S_ERROR;
   assign xfer         = byte_ready_o && byte_valid_i;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      len_d   = len_q;
      csum_d  = csum_q;
      we      = 1'b0;
      wdata   = byte_i;
      case (state_q)
         S_IDLE, S_HALTED, S_ERROR: begin
            if (load_start_i) begin
               state_d = S_CLEAR;
               wcnt_d  = '0;
            end
         end
         S_CLEAR: begin
            we     = 1'b1;
            wdata  = FILL;
            wcnt_d = (wcnt_q == (AW+1)'(DEPTH-1)) ? '0 : wcnt_q + 1'b1;
            if (wcnt_q == (AW+1)'(DEPTH-1)) state_d = S_HDR;
         end
         S_HDR: begin
            if (xfer) begin
               len_d   = byte_i[AW:0];
               csum_d  = byte_i;
               state_d = hdr_ok(byte_i) ? S_BODY : S_ERROR;
            end
         end
         S_BODY: begin
            if (xfer) begin
               we     = 1'b1;
               wcnt_d = wcnt_q + 1'b1;
               csum_d = csum_q ^ byte_i;
               if (wcnt_q == len_q - 1'b1) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (xfer) state_d = (byte_i == csum_q) ? S_RUN : S_ERROR;
         end
         S_RUN: begin
            if (halt_i) state_d = S_HALTED;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         len_q   <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         len_q   <= len_d;
         csum_q  <= csum_d;
      end
   end

   prog_ram u_ram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we),
      .waddr_i (wcnt_q[AW-1:0]),
      .wdata_i (wdata),
      .addr_i  (addr_i),
      .data_o  (data_o)
   );
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized framed loads checked against an array model of the program store.
module tb_program_loader;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       load_start = 1'b0;
   logic [7:0] byte_in = '0;
   logic       byte_valid = 1'b0;
   logic       byte_ready;
   logic [3:0] addr = '0;
   logic [7:0] data;
   logic       halt = 1'b0;
   logic       cpu_hold, loaded, load_err;

   int n_checks = 0;
   int n_fail = 0;
   logic [7:0] model_mem [16];
   logic [7:0] body [16];

   always #5 clk = ~clk;

   program_loader dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_start_i (load_start),
      .byte_i       (byte_in),
      .byte_valid_i (byte_valid),
      .byte_ready_o (byte_ready),
      .addr_i       (addr),
      .data_o       (data),
      .halt_i       (halt),
      .cpu_hold_o   (cpu_hold),
      .loaded_o     (loaded),
      .load_err_o   (load_err)
   );

   function automatic logic [7:0] body_xor(input logic [7:0] hdr);
      logic [7:0] x = hdr;
      for (int i = 0; i < 16; i++) if (i < int'(hdr)) x ^= body[i];
      return x;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit stall, output bit ok);
      ok = 1'b0;
      if (stall) repeat ($urandom_range(0, 2)) begin
         byte_valid = 1'b0;
         @(posedge clk); #1;
      end
      byte_in = b;
      byte_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (byte_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic halt_cpu();
      halt = 1'b1;
      @(posedge clk); #1;
      halt = 1'b0;
   endtask

   task automatic check_mem(input string name);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         @(posedge clk); #1;
         n_checks++;
         if (data !== model_mem[a]) begin
            n_fail++;
            $display("FAIL %s fetch[%0d]: got %h expected %h", name, a, data, model_mem[a]);
         end
      end
   endtask

   task automatic clear_wait(input string name);
      int cnt = 0;
      while (!byte_ready && cnt < 40) begin
         cnt++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (cnt !== 16) begin
         n_fail++;
         $display("FAIL %s clear_cycles: got %0d expected 16", name, cnt);
      end
      for (int i = 0; i < 16; i++) model_mem[i] = 8'hFF;
   endtask

   task automatic stream(input logic [7:0] hdr, input logic [7:0] cs, input bit stall, input string name);
      bit ok;
      bit legal = hdr != 0 && hdr <= 16 && hdr[7:5] == 0;
      bit good;
      int lost = 0;
      send_byte(hdr, stall, ok);
      if (!ok) lost++;
      if (!legal) begin
         n_checks++;
         if ({load_err, cpu_hold, loaded, byte_ready} !== 4'b1100 || lost != 0) begin
            n_fail++;
            $display("FAIL %s bad_header: err/hold/loaded/ready=%b expected 1100 timeouts=%0d", name,
                     {load_err, cpu_hold, loaded, byte_ready}, lost);
         end
         check_mem(name);
         return;
      end
      for (int i = 0; i < int'(hdr); i++) begin
         send_byte(body[i], stall, ok);
         if (!ok) lost++;
         model_mem[i] = body[i];
      end
      send_byte(cs, stall, ok);
      if (!ok) lost++;
      good = cs == body_xor(hdr);
      n_checks++;
      if ({cpu_hold, loaded, load_err, byte_ready} !== {!good, good, !good, 1'b0} || lost != 0) begin
         n_fail++;
         $display("FAIL %s outcome: hold/loaded/err/ready=%b expected %b timeouts=%0d", name,
                  {cpu_hold, loaded, load_err, byte_ready}, {!good, good, !good, 1'b0}, lost);
      end
      check_mem(name);
   endtask

   task automatic run_load(input logic [7:0] hdr, input logic [7:0] cs, input bit stall, input string name);
      if (loaded) halt_cpu();
      pulse_start();
      n_checks++;
      if ({cpu_hold, load_err, loaded} !== 3'b100) begin
         n_fail++;
         $display("FAIL %s start: hold/err/loaded=%b expected 100", name, {cpu_hold, load_err, loaded});
      end
      clear_wait(name);
      stream(hdr, cs, stall, name);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cpu_hold, byte_ready, loaded, load_err, data} !== {4'b1000, 8'h00}) begin
         n_fail++;
         $display("FAIL reset: hold/ready/loaded/err=%b data=%h expected 1000 00",
                  {cpu_hold, byte_ready, loaded, load_err}, data);
      end
      #19 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_four_instr();
      body[0] = 8'h60; body[1] = 8'h80; body[2] = 8'hA0; body[3] = 8'hC1;
      run_load(8'h04, 8'h85, 1'b0, "four_instr");
   endtask

   task automatic test_halt_reload();
      pulse_start();
      n_checks++;
      if ({loaded, cpu_hold, byte_ready} !== 3'b100) begin
         n_fail++;
         $display("FAIL start_in_run: loaded/hold/ready=%b expected 100", {loaded, cpu_hold, byte_ready});
      end
      halt_cpu();
      n_checks++;
      if ({loaded, cpu_hold} !== 2'b10) begin
         n_fail++;
         $display("FAIL halted: loaded/hold=%b expected 10", {loaded, cpu_hold});
      end
      pulse_start();
      n_checks++;
      if ({loaded, cpu_hold, byte_ready} !== 3'b010) begin
         n_fail++;
         $display("FAIL reload: loaded/hold/ready=%b expected 010", {loaded, cpu_hold, byte_ready});
      end
      clear_wait("reload");
      for (int i = 0; i < 3; i++) body[i] = 8'($urandom);
      stream(8'h03, body_xor(8'h03), 1'b1, "reload");
   endtask

   task automatic test_bad_csum();
      body[0] = 8'h60; body[1] = 8'h80; body[2] = 8'hA0; body[3] = 8'hC1;
      run_load(8'h04, 8'h00, 1'b0, "bad_csum");
      body[0] = 8'h11;
      run_load(8'h01, body_xor(8'h01), 1'b0, "after_bad_csum");
   endtask

   task automatic test_illegal_hdr();
      logic [7:0] hs [3] = '{8'h00, 8'h11, 8'h24};
      foreach (hs[i]) run_load(hs[i], 8'h00, 1'b0, "illegal_hdr");
   endtask

   task automatic test_full_depth();
      for (int i = 0; i < 16; i++) body[i] = 8'($urandom);
      run_load(8'h10, body_xor(8'h10), 1'b1, "full_depth");
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         logic [7:0] len = 8'($urandom_range(1, 16));
         logic [7:0] cs;
         for (int i = 0; i < 16; i++) body[i] = 8'($urandom);
         cs = body_xor(len);
         if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
         run_load(len, cs, 1'($urandom), "random");
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      if (loaded) halt_cpu();
      pulse_start();
      clear_wait("async_reset");
      send_byte(8'h08, 1'b0, ok);
      for (int i = 0; i < 3; i++) begin
         body[i] = 8'($urandom);
         send_byte(body[i], 1'b0, ok);
         model_mem[i] = body[i];
      end
      addr = 4'd0;
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cpu_hold, byte_ready, loaded, load_err, data} !== {4'b1000, 8'h00} || !ok) begin
         n_fail++;
         $display("FAIL async_reset: hold/ready/loaded/err=%b data=%h expected 1000 00 ok=%0d",
                  {cpu_hold, byte_ready, loaded, load_err}, data, ok);
      end
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({cpu_hold, byte_ready, loaded} !== 3'b100) begin
         n_fail++;
         $display("FAIL idle_after_reset: hold/ready/loaded=%b expected 100", {cpu_hold, byte_ready, loaded});
      end
      check_mem("partial_program");
   endtask

   initial begin
      test_reset();
      test_four_instr();
      test_halt_reload();
      test_bad_csum();
      test_illegal_hdr();
      test_full_depth();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
